// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the dm_sized byte-addressable data memory.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {CLEAR, IDLE} state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << ofs;
      SZ_H:    lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // The reserved size code is always treated as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = ofs[0];
      SZ_W:    misaligned = |ofs;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] ofs, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = ofs[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    extend = {{24{sext & b[7]}}, b};
      SZ_H:    extend = {{16{sext & h[15]}}, h};
      default: extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word array with per-byte write enables and a registered read port.
// DM_RDW_BYPASS_EN adds a second read-only port with write-first bypass.
module dm_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
`ifdef DM_RDW_BYPASS_EN
  ,
  input  logic          re2,
  input  logic [AW-1:0] addr2,
  output logic [31:0]   rdata2
`endif
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

`ifdef DM_RDW_BYPASS_EN
  logic [31:0] merged;

  // Lanes being written this cycle come from wdata so the second port sees the new word.
  always_comb begin
    merged = mem[addr2];
    for (int i = 0; i < 4; i++) begin
      if (we && be[i] && (addr == addr2)) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !re2) rdata2 <= '0;
    else             rdata2 <= merged;
  end
`endif

endmodule

// File: rtl/dm_sized.sv
// Byte-addressable MIPS data memory: clear sequencer, alignment check and load formatting.
// Optional second read port is enabled by defining DM_RDW_BYPASS_EN.
module dm_sized
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign
`ifdef DM_RDW_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
`endif
);

  localparam int AW = ADDR_W - 2;

  if (DATA_W != 32) begin : g_width_check
    $error("dm_sized: DATA_W must be 32");
  end

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          clearing, accept, bad_align, do_store, do_load;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   wrep, ram_wdata, ram_rdata;
  logic [1:0]    size_q, ofs_q;
  logic          sext_q;

  assign ready     = (state == IDLE);
  assign clearing  = (state == CLEAR) && !rst;
  assign accept    = req && ready && !rst;
  assign bad_align = misaligned(size, addr[1:0]);
  assign do_store  = accept && we && !bad_align;
  assign do_load   = accept && !we && !bad_align;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == {AW{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the ones that land.
  always_comb begin
    wrep = wdata;
    case (size)
      SZ_B:    wrep = {4{wdata[7:0]}};
      SZ_H:    wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  assign ram_we    = clearing || do_store;
  assign ram_be    = clearing ? 4'b1111 : lane_mask(size, addr[1:0]);
  assign ram_addr  = clearing ? cnt : addr[ADDR_W-1:2];
  assign ram_wdata = clearing ? 32'd0 : wrep;

  dm_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (do_load),
    .rdata (ram_rdata)
`ifdef DM_RDW_BYPASS_EN
    ,
    .re2   (ready),
    .addr2 (raddr2[ADDR_W-1:2]),
    .rdata2(rdata2)
`endif
  );

  // Lane selection travels with the read so formatting lines up with the registered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      size_q   <= SZ_B;
      ofs_q    <= 2'b00;
      sext_q   <= 1'b0;
    end else begin
      rvalid   <= do_load;
      misalign <= accept && bad_align;
      if (do_load) begin
        size_q <= size;
        ofs_q  <= addr[1:0];
        sext_q <= sext;
      end
    end
  end

  assign rdata = extend(ram_rdata, size_q, ofs_q, sext_q);

endmodule
